// File: rtl/pc_next_seq.sv
// pc_next_seq -- next-PC sequencer with an optional return-address stack.
//
// Chooses the value loaded into the PC register each cycle. The sources are
// sequential (in_pc+2), a taken branch (in_pc+offset), an absolute jump or
// call (in_jump_target) and a return (the top of the return-address stack).
// Every redirect is followed by one REDIRECT cycle. That cycle flushes the
// instruction in fetch and does not write the PC.
//
// Parameters
//   RESET_VECTOR  first PC loaded after reset
//   RAS_DEPTH     return-address-stack entries (power of two, 2..8)
//
// Build option
//   PC_NEXT_SEQ_RAS_EN  defined   : return-address stack is implemented
//                       undefined : no stack; call and ret both act as a
//                                   jump to in_jump_target; out_ras_err = 0
//
// Ports
//   CLK               clock, rising edge
//   RST               synchronous active-high reset
//   in_pc             current PC
//   in_stall          hold PC, no state change
//   in_branch_taken   conditional branch resolved taken
//   in_branch_offset  signed byte offset relative to in_pc
//   in_jump           absolute jump to in_jump_target
//   in_call           jump to in_jump_target and push in_pc+2
//   in_ret            return to popped top-of-stack
//   in_jump_target    absolute jump/call target
//   out_next_pc       value to load into the PC register
//   out_pc_write      PC register write enable
//   out_flush         kill the instruction in fetch
//   out_ras_err       one-cycle pulse on stack overflow/underflow
module pc_next_seq #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] in_pc,
  input  logic        in_stall,
  input  logic        in_branch_taken,
  input  logic [15:0] in_branch_offset,
  input  logic        in_jump,
  input  logic        in_call,
  input  logic        in_ret,
  input  logic [15:0] in_jump_target,
  output logic [15:0] out_next_pc,
  output logic        out_pc_write,
  output logic        out_flush,
  output logic        out_ras_err
);

  if ((RAS_DEPTH < 2) || (RAS_DEPTH > 8) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_next_seq: RAS_DEPTH must be a power of two in 2..8");
  end

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [15:0] seq_pc;
  logic [15:0] br_pc;

  // Modulo-2^16 PC plus signed offset. Two's complement addition wraps
  // naturally, so the offset is reinterpreted as unsigned bits.
  function automatic logic [15:0] pc_rel(input logic [15:0] base,
                                         input logic signed [15:0] off);
    return base + $unsigned(off);
  endfunction

  assign seq_pc = pc_rel(in_pc, 16'sd2);
  assign br_pc  = pc_rel(in_pc, $signed(in_branch_offset));

`ifdef PC_NEXT_SEQ_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;   // next free slot; top of stack is ras_ptr-1
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_full, ras_empty;
  logic             ras_push, ras_pop;
  logic [15:0]      ras_top;

  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_mem[ras_ptr - PTR_W'(1)];
`endif

  always_comb begin
    state_nxt    = state;
    out_next_pc  = seq_pc;
    out_pc_write = 1'b0;
    out_flush    = 1'b0;
    out_ras_err  = 1'b0;
`ifdef PC_NEXT_SEQ_RAS_EN
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
`endif
    case (state)
      BOOT: begin
        out_next_pc  = RESET_VECTOR;
        out_pc_write = 1'b1;
        out_flush    = 1'b1;
        state_nxt    = RUN;
      end
      RUN: begin
        if (!in_stall) begin
          out_pc_write = 1'b1;
          if (in_ret) begin
            state_nxt = REDIRECT;
`ifdef PC_NEXT_SEQ_RAS_EN
            // Underflow still redirects, but it falls through to in_pc+2.
            if (ras_empty) begin
              out_next_pc = seq_pc;
              out_ras_err = 1'b1;
            end else begin
              out_next_pc = ras_top;
              ras_pop     = 1'b1;
            end
`else
            out_next_pc = in_jump_target;
`endif
          end else if (in_call) begin
            state_nxt   = REDIRECT;
            out_next_pc = in_jump_target;
`ifdef PC_NEXT_SEQ_RAS_EN
            ras_push    = 1'b1;
            out_ras_err = ras_full;
`endif
          end else if (in_jump) begin
            state_nxt   = REDIRECT;
            out_next_pc = in_jump_target;
          end else if (in_branch_taken) begin
            state_nxt   = REDIRECT;
            out_next_pc = br_pc;
          end
        end
      end
      REDIRECT: begin
        out_flush = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase

    // Reset overrides everything, including any pending stack operation.
    if (RST) begin
      out_next_pc  = RESET_VECTOR;
      out_pc_write = 1'b0;
      out_flush    = 1'b1;
      out_ras_err  = 1'b0;
`ifdef PC_NEXT_SEQ_RAS_EN
      ras_push     = 1'b0;
      ras_pop      = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= BOOT;
    else     state <= state_nxt;
  end

`ifdef PC_NEXT_SEQ_RAS_EN
  // Stack contents are data; only the pointer and count are reset.
  always_ff @(posedge CLK) begin
    if (ras_push) ras_mem[ras_ptr] <= seq_pc;
  end

  // Circular stack. A push when full lands on the oldest slot, so the count
  // saturates at RAS_DEPTH while the pointer keeps wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - PTR_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_next_seq.sv
module tb_pc_next_seq;

`ifdef PC_NEXT_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] in_pc;
  logic        in_stall;
  logic        in_branch_taken;
  logic [15:0] in_branch_offset;
  logic        in_jump;
  logic        in_call;
  logic        in_ret;
  logic [15:0] in_jump_target;
  logic [15:0] out_next_pc;
  logic        out_pc_write;
  logic        out_flush;
  logic        out_ras_err;

  int n_chk  = 0;
  int n_fail = 0;

  pc_next_seq #(.RESET_VECTOR(16'h0000), .RAS_DEPTH(4)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .in_pc            (in_pc),
    .in_stall         (in_stall),
    .in_branch_taken  (in_branch_taken),
    .in_branch_offset (in_branch_offset),
    .in_jump          (in_jump),
    .in_call          (in_call),
    .in_ret           (in_ret),
    .in_jump_target   (in_jump_target),
    .out_next_pc      (out_next_pc),
    .out_pc_write     (out_pc_write),
    .out_flush        (out_flush),
    .out_ras_err      (out_ras_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    in_stall = 0; in_branch_taken = 0; in_branch_offset = 16'h0000;
    in_jump = 0; in_call = 0; in_ret = 0; in_jump_target = 16'h0000;
  endtask

  // Check all four outputs 1 ns after the inputs have been applied.
  task automatic expect_out(input string tag, input logic [15:0] pc,
                            input logic wr, input logic fl, input logic err);
    #1;
    check_eq({tag, ".next_pc"}, out_next_pc, pc);
    check_eq({tag, ".pc_write"}, {15'd0, out_pc_write}, {15'd0, wr});
    check_eq({tag, ".flush"}, {15'd0, out_flush}, {15'd0, fl});
    check_eq({tag, ".ras_err"}, {15'd0, out_ras_err}, {15'd0, err});
  endtask

  // Check only the REDIRECT-cycle controls (next_pc is don't-care there).
  task automatic expect_redir(input string tag);
    #1;
    check_eq({tag, ".redir_write"}, {15'd0, out_pc_write}, 16'd0);
    check_eq({tag, ".redir_flush"}, {15'd0, out_flush}, 16'd1);
    check_eq({tag, ".redir_err"}, {15'd0, out_ras_err}, 16'd0);
  endtask

  logic [15:0] call_pc [5] = '{16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h1400};
  logic [15:0] ret_exp [5] = '{16'h1402, 16'h1302, 16'h1202, 16'h1102, 16'h2002};

  initial begin
    RST = 1; in_pc = 16'h0000; clr_in();
    // Reset held for two cycles; outputs forced to their reset values.
    #1;
    expect_out("rst", 16'h0000, 0, 1, 0);
    tick(); tick();
    RST = 0;
    expect_out("boot", 16'h0000, 1, 1, 0);
    tick();
    in_pc = 16'h0000;
    expect_out("seq0", 16'h0002, 1, 0, 0);

    // Taken branch backwards, then its REDIRECT with a stray jump ignored.
    tick();
    in_pc = 16'h0100; in_branch_taken = 1; in_branch_offset = 16'hFFF0;
    expect_out("branch", 16'h00F0, 1, 0, 0);
    tick(); clr_in(); in_jump = 1; in_jump_target = 16'h0ABC;
    expect_redir("branch");
    tick(); clr_in();

    // Sequential wrap at the top of the address space.
    in_pc = 16'hFFFE;
    expect_out("wrap", 16'h0000, 1, 0, 0);

    // Stall with a jump: nothing written, no REDIRECT follows.
    tick();
    in_stall = 1; in_jump = 1; in_jump_target = 16'h1234; in_pc = 16'h0010;
    expect_out("stall", 16'h0012, 0, 0, 0);
    tick(); clr_in();
    expect_out("post_stall", 16'h0012, 1, 0, 0);

    // Plain jump.
    tick();
    in_jump = 1; in_jump_target = 16'h0300;
    expect_out("jump", 16'h0300, 1, 0, 0);
    tick(); clr_in();
    expect_redir("jump");

    // Call then return; the return also raises jump and branch.
    tick();
    in_pc = 16'h0040; in_call = 1; in_jump_target = 16'h0200;
    expect_out("call", 16'h0200, 1, 0, 0);
    tick(); clr_in();
    expect_redir("call");
    tick();
    in_pc = 16'h0210; in_ret = 1; in_jump = 1; in_branch_taken = 1;
    in_branch_offset = 16'h0010; in_jump_target = 16'h0500;
    expect_out("ret_prio", RAS_EN ? 16'h0042 : 16'h0500, 1, 0, 0);
    tick(); clr_in();
    expect_redir("ret_prio");

    // Five calls into a four-deep stack: the fifth overflows.
    for (int i = 0; i < 5; i++) begin
      tick();
      in_pc = call_pc[i]; in_call = 1; in_jump_target = 16'h0600;
      expect_out($sformatf("call%0d", i), 16'h0600, 1, 0, (RAS_EN && i == 4));
      tick(); clr_in();
      expect_redir($sformatf("call%0d", i));
    end

    // Five returns: four stacked addresses, then underflow to in_pc+2.
    for (int i = 0; i < 5; i++) begin
      tick();
      in_pc = 16'h2000; in_ret = 1; in_jump_target = 16'h0700;
      expect_out($sformatf("ret%0d", i), RAS_EN ? ret_exp[i] : 16'h0700, 1, 0,
                 (RAS_EN && i == 4));
      tick(); clr_in();
      expect_redir($sformatf("ret%0d", i));
    end

    // Reset asserted during REDIRECT abandons it; next cycle is BOOT.
    tick();
    in_pc = 16'h0080; in_jump = 1; in_jump_target = 16'h0900;
    expect_out("jump2", 16'h0900, 1, 0, 0);
    tick(); clr_in();
    RST = 1;
    expect_out("rst_redir", 16'h0000, 0, 1, 0);
    tick();
    RST = 0;
    expect_out("boot2", 16'h0000, 1, 1, 0);
    tick();
    in_pc = 16'h0000;
    expect_out("seq1", 16'h0002, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_next_seq.md
PC_NEXT_SEQ -- requirements
Module: pc_next_seq

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000, first PC loaded after reset.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..8).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 in_pc  input  16  current PC from PC register.
REQ-006 in_stall  input  1  hold PC; no state change.
REQ-007 in_branch_taken  input  1  conditional branch resolved taken.
REQ-008 in_branch_offset  input  16  signed byte offset, relative to in_pc.
REQ-009 in_jump  input  1  absolute jump to in_jump_target.
REQ-010 in_call  input  1  jump to in_jump_target and push return address.
REQ-011 in_ret  input  1  return: pop RAS into next PC.
REQ-012 in_jump_target  input  16  absolute target for jump/call.
REQ-013 out_next_pc  output  16  value to load into PC register.
REQ-014 out_pc_write  output  1  write enable for PC register.
REQ-015 out_flush  output  1  kill the instruction in fetch.
REQ-016 out_ras_err  output  1  one-cycle pulse on RAS overflow or underflow.

Function
REQ-017 FSM states SHALL be BOOT, RUN, REDIRECT; state and RAS registered; out_* combinational from state, RAS and inputs.
REQ-018 BOOT: out_next_pc=RESET_VECTOR, out_pc_write=1, out_flush=1, inputs ignored; next state RUN unconditionally.
REQ-019 RUN, in_stall=1: out_pc_write=0, out_flush=0, RAS and state unchanged, all control inputs ignored.
REQ-020 RUN, no control input: out_next_pc=in_pc+2, out_pc_write=1, remain RUN.
REQ-021 Control priority (RUN, not stalled): in_ret > in_call > in_jump > in_branch_taken > sequential.
REQ-022 Branch: out_next_pc=in_pc+in_branch_offset; jump: in_jump_target; call: in_jump_target plus push in_pc+2; ret: popped top-of-stack.
REQ-023 Any taken redirect (ret/call/jump/branch): out_pc_write=1 this cycle, next state REDIRECT.
REQ-024 REDIRECT: exactly one cycle, out_pc_write=0, out_flush=1, inputs and in_stall ignored, RAS unchanged; next state RUN.
REQ-025 All PC arithmetic modulo 2^16; 16'hFFFE+2=16'h0000 with no flag.
REQ-026 RAS push when full: overwrite oldest entry (circular), count stays RAS_DEPTH, out_ras_err=1 for that cycle.
REQ-027 RAS pop when empty: out_next_pc=in_pc+2, redirect still taken, out_ras_err=1, count stays 0.
REQ-028 out_ras_err SHALL be 0 in every cycle without an overflow/underflow event.

Reset
REQ-029 RST=1 at rising edge: state<=BOOT, RAS count<=0; RAS entry contents need not be cleared.
REQ-030 While RST=1: out_pc_write=0, out_flush=1, out_ras_err=0, out_next_pc=RESET_VECTOR.
REQ-031 RST mid-REDIRECT or mid-stall SHALL abandon the operation; first post-reset cycle is BOOT.

Configuration
REQ-032 Macro PC_NEXT_SEQ_RAS_EN defined: RAS implemented per REQ-022/026/027.
REQ-033 Macro undefined: no RAS storage; in_call behaves as in_jump; in_ret behaves as in_jump (target in_jump_target); out_ras_err tied 0; priority order otherwise unchanged.

Verification
REQ-034 RST high 2 cycles, release -> BOOT cycle out_next_pc=16'h0000, out_pc_write=1; then in_pc=0 gives out_next_pc=16'h0002.
REQ-035 RUN, in_pc=16'h0100, in_branch_taken=1, offset=16'hFFF0 -> out_next_pc=16'h00F0, out_pc_write=1; next cycle out_flush=1, out_pc_write=0.
REQ-036 in_pc=16'h0040, in_call=1, target=16'h0200; later in_pc=16'h0210, in_ret=1 -> out_next_pc=16'h0042 (RAS_EN).
REQ-037 Five calls with RAS_DEPTH=4 -> fifth asserts out_ras_err; five rets return last four addresses then underflow with out_ras_err=1, out_next_pc=in_pc+2.
REQ-038 in_stall=1 with in_jump=1 -> out_pc_write=0, no REDIRECT; in_ret+in_jump+in_branch_taken together -> ret target wins.
REQ-039 in_pc=16'hFFFE, no control -> out_next_pc=16'h0000; RST asserted during REDIRECT -> next cycle after release is BOOT.
